// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: instruction fetch front end for the in-order shift-register pipeline.
// It walks a program counter and fetches words over a req/ack handshake into a prefetch FIFO.
// It issues the FIFO head on inst, with enable marking the cycles the pipeline advances.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   start, start_addr        leave IDLE and begin fetching at start_addr
//   flush, flush_addr        drop buffered and in-flight words, redirect fetch to flush_addr
//   stall                    downstream hold; suppresses issue
//   mem_req, mem_addr        registered fetch request and address (mem_addr is the PC)
//   mem_ack, mem_rdata       memory response, sampled only while mem_req is high
//   inst, enable             FIFO head (0 when empty) and pipeline advance / FIFO pop
//   fifo_count               FIFO occupancy
module inst_fetch_queue #(
    parameter int unsigned IW    = 9,
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [AW-1:0]            start_addr,
    input  logic                     flush,
    input  logic [AW-1:0]            flush_addr,
    input  logic                     stall,
    output logic                     mem_req,
    output logic [AW-1:0]            mem_addr,
    input  logic                     mem_ack,
    input  logic [IW-1:0]            mem_rdata,
    output logic [IW-1:0]            inst,
    output logic                     enable,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetchState_t;

    fetchState_t   state;
    fetchState_t   stateNext;
    logic [AW-1:0] pc;
    logic [AW-1:0] pcNext;
    logic [IW-1:0] fifoMem [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [CW-1:0] count;
    logic [CW-1:0] countAfter;
    logic          pushEn;
    logic          clearFifo;

    assign mem_addr   = pc;
    assign fifo_count = count;
    assign inst       = (count != '0) ? fifoMem[rdPtr] : '0;

    // Next-state, PC and FIFO control; flush outranks every other event.
    always_comb begin
        stateNext  = state;
        pcNext     = pc;
        clearFifo  = 1'b0;
        enable     = (count != '0) && !stall && !flush;
        pushEn     = (state == REQ) && mem_req && mem_ack && !flush;
        countAfter = count + CW'(pushEn) - CW'(enable);

        case (state)
            IDLE: begin
                if (flush) begin
                    stateNext = REQ;
                    pcNext    = flush_addr;
                    clearFifo = 1'b1;
                end else if (start) begin
                    stateNext = REQ;
                    pcNext    = start_addr;
                end
            end
            REQ: begin
                if (flush) begin
                    pcNext    = flush_addr;
                    clearFifo = 1'b1;
                end else if (pushEn) begin
                    pcNext = pc + AW'(1);
                    // Stop requesting once this push fills the FIFO.
                    if (countAfter == CW'(DEPTH)) begin
                        stateNext = HOLD;
                    end
                end
            end
            HOLD: begin
                if (flush) begin
                    stateNext = REQ;
                    pcNext    = flush_addr;
                    clearFifo = 1'b1;
                end else if (enable) begin
                    // A pop frees a slot; request again from the next cycle.
                    stateNext = REQ;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State, PC, request and FIFO bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= '0;
            mem_req <= 1'b0;
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
        end else begin
            state   <= stateNext;
            pc      <= pcNext;
            mem_req <= (stateNext == REQ);
            if (clearFifo) begin
                wrPtr <= '0;
                rdPtr <= '0;
                count <= '0;
            end else begin
                if (pushEn) begin
                    wrPtr <= wrPtr + PW'(1);
                end
                if (enable) begin
                    rdPtr <= rdPtr + PW'(1);
                end
                count <= countAfter;
            end
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            fifoMem[wrPtr] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] start_addr = '0;
    logic       flush = 1'b0;
    logic [7:0] flush_addr = '0;
    logic       stall = 1'b0;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [8:0] mem_rdata;
    logic [8:0] inst;
    logic       enable;
    logic [2:0] fifo_count;

    logic       ackEn = 1'b0;
    logic [8:0] memData [256];

    int nVec = 0;
    int nErr = 0;

    logic [8:0] expQ [$];
    logic [7:0] expPc = '0;
    bit         modelIdle = 1'b1;

    inst_fetch_queue #(.IW(9), .AW(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .flush      (flush),
        .flush_addr (flush_addr),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .inst       (inst),
        .enable     (enable),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Memory model: acks in the same cycle as the request whenever ackEn is set.
    assign mem_ack   = ackEn & mem_req;
    assign mem_rdata = memData[mem_addr];

    typedef struct {
        logic       r, s, f, st, a, c;
        logic [7:0] sa, fa;
        logic       eReq;
        logic [7:0] eAddr;
        logic       eEn;
        logic [2:0] eCnt;
    } vec_t;

    function automatic vec_t V(input logic r, s, f, st, a, c, input logic [7:0] sa, fa,
                               input logic eReq, input logic [7:0] eAddr,
                               input logic eEn, input logic [2:0] eCnt);
        vec_t v;
        v.r = r; v.s = s; v.f = f; v.st = st; v.a = a; v.c = c;
        v.sa = sa; v.fa = fa; v.eReq = eReq; v.eAddr = eAddr; v.eEn = eEn; v.eCnt = eCnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus after the edge, check outputs mid-cycle.
    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        rst = v.r; start = v.s; flush = v.f; stall = v.st; ackEn = v.a;
        start_addr = v.sa; flush_addr = v.fa;
        @(negedge clk);
        if (v.c) begin
            check("mem_req", 32'(mem_req), 32'(v.eReq));
            check("mem_addr", 32'(mem_addr), 32'(v.eAddr));
            check("enable", 32'(enable), 32'(v.eEn));
            check("fifo_count", 32'(fifo_count), 32'(v.eCnt));
        end
    endtask

    // Scoreboard: expected words enter on each accepted ack, leave on each issue.
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
            modelIdle = 1'b1;
        end else begin
            logic expEn;
            expEn = (expQ.size() != 0) && !stall && !flush;
            check("sb_enable", 32'(enable), 32'(expEn));
            check("sb_count", 32'(fifo_count), 32'(expQ.size()));
            check("sb_inst", 32'(inst), (expQ.size() != 0) ? 32'(expQ[0]) : 32'd0);
            if (flush) begin
                expQ.delete();
                expPc = flush_addr;
                modelIdle = 1'b0;
            end else begin
                if (expEn && expQ.size() != 0) void'(expQ.pop_front());
                if (modelIdle) begin
                    if (start) begin
                        expPc = start_addr;
                        modelIdle = 1'b0;
                    end
                end else if (mem_req && mem_ack) begin
                    check("sb_fetch_addr", 32'(mem_addr), 32'(expPc));
                    expQ.push_back(memData[expPc]);
                    expPc = expPc + 8'd1;
                end
            end
        end
    end

    vec_t tbl [$];

    initial begin
        for (int a = 0; a < 256; a++) memData[a] = 9'((a * 37 + 11) % 512);

        // Tests 1-2: same-cycle ack, then stall until full, then release.
        tbl.push_back(V(1,0,0,0,0,0, 8'h00,8'h00, 0,8'h00,0,3'd0));
        tbl.push_back(V(1,0,0,0,0,0, 8'h00,8'h00, 0,8'h00,0,3'd0));
        tbl.push_back(V(0,1,0,0,1,1, 8'h10,8'h00, 0,8'h00,0,3'd0));
        tbl.push_back(V(0,0,0,0,1,1, 8'h00,8'h00, 1,8'h10,0,3'd0));
        tbl.push_back(V(0,0,0,0,1,1, 8'h00,8'h00, 1,8'h11,1,3'd1));
        tbl.push_back(V(0,0,0,0,1,1, 8'h00,8'h00, 1,8'h12,1,3'd1));
        tbl.push_back(V(0,0,0,0,1,1, 8'h00,8'h00, 1,8'h13,1,3'd1));
        tbl.push_back(V(0,0,0,1,1,1, 8'h00,8'h00, 1,8'h14,0,3'd1));
        tbl.push_back(V(0,0,0,1,1,1, 8'h00,8'h00, 1,8'h15,0,3'd2));
        tbl.push_back(V(0,0,0,1,1,1, 8'h00,8'h00, 1,8'h16,0,3'd3));
        tbl.push_back(V(0,0,0,1,1,1, 8'h00,8'h00, 0,8'h17,0,3'd4));
        tbl.push_back(V(0,0,0,1,1,1, 8'h00,8'h00, 0,8'h17,0,3'd4));
        tbl.push_back(V(0,0,0,0,1,1, 8'h00,8'h00, 0,8'h17,1,3'd4));
        tbl.push_back(V(0,0,0,0,1,1, 8'h00,8'h00, 1,8'h17,1,3'd3));
        tbl.push_back(V(0,0,0,0,1,1, 8'h00,8'h00, 1,8'h18,1,3'd3));
        tbl.push_back(V(0,0,0,0,1,1, 8'h00,8'h00, 1,8'h19,1,3'd3));
        tbl.push_back(V(0,0,0,0,1,1, 8'h00,8'h00, 1,8'h1A,1,3'd3));
        // Test 3: PC wrap.
        tbl.push_back(V(1,0,0,0,1,0, 8'h00,8'h00, 0,8'h00,0,3'd0));
        tbl.push_back(V(0,1,0,0,1,1, 8'hFE,8'h00, 0,8'h00,0,3'd0));
        tbl.push_back(V(0,0,0,0,1,1, 8'h00,8'h00, 1,8'hFE,0,3'd0));
        tbl.push_back(V(0,0,0,0,1,1, 8'h00,8'h00, 1,8'hFF,1,3'd1));
        tbl.push_back(V(0,0,0,0,1,1, 8'h00,8'h00, 1,8'h00,1,3'd1));
        tbl.push_back(V(0,0,0,0,1,1, 8'h00,8'h00, 1,8'h01,1,3'd1));
        // Test 4: flush with a same-cycle ack, then flush while full in HOLD.
        tbl.push_back(V(1,0,0,0,1,0, 8'h00,8'h00, 0,8'h00,0,3'd0));
        tbl.push_back(V(0,1,0,1,1,1, 8'h20,8'h00, 0,8'h00,0,3'd0));
        tbl.push_back(V(0,0,0,1,1,1, 8'h00,8'h00, 1,8'h20,0,3'd0));
        tbl.push_back(V(0,0,0,1,1,1, 8'h00,8'h00, 1,8'h21,0,3'd1));
        tbl.push_back(V(0,0,0,1,1,1, 8'h00,8'h00, 1,8'h22,0,3'd2));
        tbl.push_back(V(0,0,1,1,1,1, 8'h00,8'h40, 1,8'h23,0,3'd3));
        tbl.push_back(V(0,0,0,0,1,1, 8'h00,8'h00, 1,8'h40,0,3'd0));
        tbl.push_back(V(0,0,0,0,1,1, 8'h00,8'h00, 1,8'h41,1,3'd1));
        tbl.push_back(V(0,0,0,0,1,1, 8'h00,8'h00, 1,8'h42,1,3'd1));
        tbl.push_back(V(0,0,0,1,1,1, 8'h00,8'h00, 1,8'h43,0,3'd1));
        tbl.push_back(V(0,0,0,1,1,1, 8'h00,8'h00, 1,8'h44,0,3'd2));
        tbl.push_back(V(0,0,0,1,1,1, 8'h00,8'h00, 1,8'h45,0,3'd3));
        tbl.push_back(V(0,0,1,1,1,1, 8'h00,8'h80, 0,8'h46,0,3'd4));
        tbl.push_back(V(0,0,0,0,1,1, 8'h00,8'h00, 1,8'h80,0,3'd0));
        tbl.push_back(V(0,0,0,0,1,1, 8'h00,8'h00, 1,8'h81,1,3'd1));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Test 5: ack held off for three cycles; request must stay put, one push only.
        apply(V(1,0,0,0,0,0, 8'h00,8'h00, 0,8'h00,0,3'd0));
        apply(V(0,1,0,0,0,1, 8'h30,8'h00, 0,8'h00,0,3'd0));
        apply(V(0,0,0,0,0,1, 8'h00,8'h00, 1,8'h30,0,3'd0));
        apply(V(0,0,0,0,0,1, 8'h00,8'h00, 1,8'h30,0,3'd0));
        apply(V(0,0,0,0,0,1, 8'h00,8'h00, 1,8'h30,0,3'd0));
        apply(V(0,0,0,0,1,1, 8'h00,8'h00, 1,8'h30,0,3'd0));
        apply(V(0,0,0,0,0,1, 8'h00,8'h00, 1,8'h31,1,3'd1));
        apply(V(0,0,0,0,0,1, 8'h00,8'h00, 1,8'h31,0,3'd0));
        apply(V(0,0,0,0,0,1, 8'h00,8'h00, 1,8'h31,0,3'd0));

        // Test 6: reset mid-handshake with two words buffered, then refetch from 0.
        apply(V(1,0,0,0,0,0, 8'h00,8'h00, 0,8'h00,0,3'd0));
        apply(V(0,1,0,1,1,1, 8'h00,8'h00, 0,8'h00,0,3'd0));
        apply(V(0,0,0,1,1,1, 8'h00,8'h00, 1,8'h00,0,3'd0));
        apply(V(0,0,0,1,1,1, 8'h00,8'h00, 1,8'h01,0,3'd1));
        apply(V(1,0,0,1,1,1, 8'h00,8'h00, 1,8'h02,0,3'd2));
        apply(V(0,0,0,0,1,1, 8'h00,8'h00, 0,8'h00,0,3'd0));
        check("inst_after_rst", 32'(inst), 32'd0);
        apply(V(0,1,0,0,1,1, 8'h00,8'h00, 0,8'h00,0,3'd0));
        apply(V(0,0,0,0,1,1, 8'h00,8'h00, 1,8'h00,0,3'd0));
        apply(V(0,0,0,0,1,1, 8'h00,8'h00, 1,8'h01,1,3'd1));
        check("refetch_word0", 32'(inst), 32'(memData[0]));
        apply(V(0,0,0,0,1,1, 8'h00,8'h00, 1,8'h02,1,3'd1));
        check("refetch_word1", 32'(inst), 32'(memData[1]));
        apply(V(0,0,0,0,0,1, 8'h00,8'h00, 1,8'h03,1,3'd1));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
